// File: rtl/spi_pkg.sv
// Shared SPI master types: FSM state encoding and {cpol,cpha} mode constants.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      XFER  = 3'd2,
      NEXT  = 3'd3,
      HOLD  = 3'd4,
      DESEL = 3'd5
   } spi_state_e;

   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period divider and SCLK generator; tick fires when the counter reaches div.
// Edges alternate leading/trailing by parity of the caller's edge index.
module spi_clk_gen #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cnt_en,
   input  logic [DIV_W-1:0] div,
   input  logic             xfer,
   input  logic             edge_par,
   input  logic             idle_load,
   input  logic             idle_lvl,
   output logic             tick,
   output logic             lead_edge,
   output logic             trail_edge,
   output logic             sclk
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             sclk_q, sclk_d;

   assign tick       = cnt_en && (cnt_q == div);
   assign lead_edge  = tick && xfer && !edge_par;
   assign trail_edge = tick && xfer && edge_par;
   assign sclk       = sclk_q;

   always_comb begin
      cnt_d  = '0;
      sclk_d = sclk_q;
      if (cnt_en && !tick) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (idle_load) begin
         sclk_d = idle_lvl;
      end else if (lead_edge || trail_edge) begin
         sclk_d = !sclk_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

endmodule

// File: rtl/spi_master_cfg.sv
// SPI master with runtime CPOL/CPHA, bit order, divider and chip select; bursts share one CS.
// Single word: rx_valid rises (cfg_div+1)*(2*DATA_W+1) cycles after the accepting edge.
module spi_master_cfg
   import spi_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DIV_W  = 8,
   parameter int NUM_CS = 1,
   localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_cpol,
   input  logic              cfg_cpha,
   input  logic              cfg_lsb_first,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [CS_W-1:0]   cfg_cs_sel,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_last,
   output logic              rx_valid,
   output logic [DATA_W-1:0] rx_data,
   output logic              busy,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_CS-1:0] cs_n
);

   localparam int EC_W  = $clog2(2 * DATA_W);
   localparam int CS_WP = CS_W + 1;
   localparam logic [EC_W-1:0]  EDGE_LAST = EC_W'(2 * DATA_W - 1);
   localparam logic [CS_W:0]    NUM_CS_L  = CS_WP'(NUM_CS);

   spi_state_e        state_q, state_d;
   logic [DATA_W-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
   logic [EC_W-1:0]   edge_cnt_q, edge_cnt_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [NUM_CS-1:0] cs_n_q, cs_n_d;
   logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, last_q, last_d;
   logic              mosi_q, mosi_d, rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;

   logic              tick, lead_edge, trail_edge, any_edge, sample, shift, last_edge;
   logic              accept, lsb_eff;
   logic [CS_W-1:0]   sel_in;
   logic [DATA_W-1:0] rx_shifted;

   spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
      .clk        (clk),
      .rst        (rst),
      .cnt_en     (state_q inside {SETUP, XFER, HOLD, DESEL}),
      .div        (div_q),
      .xfer       (state_q == XFER),
      .edge_par   (edge_cnt_q[0]),
      .idle_load  (state_q != XFER),
      .idle_lvl   ((state_q == IDLE) ? cfg_cpol : cpol_q),
      .tick       (tick),
      .lead_edge  (lead_edge),
      .trail_edge (trail_edge),
      .sclk       (sclk)
   );

   assign accept     = tx_valid && tx_ready_q;
   assign lsb_eff    = (state_q == IDLE) ? cfg_lsb_first : lsb_q;
   assign sel_in     = ({1'b0, cfg_cs_sel} < NUM_CS_L) ? cfg_cs_sel : '0;
   assign any_edge   = lead_edge || trail_edge;
   assign sample     = cpha_q ? trail_edge : lead_edge;
   // First bit is already on MOSI at load, and nothing follows the final edge.
   assign shift      = (cpha_q ? lead_edge : trail_edge) && (edge_cnt_q != '0)
                       && (edge_cnt_q != EDGE_LAST);
   assign last_edge  = any_edge && (edge_cnt_q == EDGE_LAST);
   assign rx_shifted = lsb_q ? {miso, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], miso};

   always_comb begin
      state_d    = state_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      edge_cnt_d = edge_cnt_q;
      div_d      = div_q;
      cs_n_d     = cs_n_q;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      lsb_d      = lsb_q;
      last_d     = last_q;
      mosi_d     = mosi_q;

      if (accept) begin
         tx_sr_d    = lsb_eff ? (tx_data >> 1) : (tx_data << 1);
         mosi_d     = lsb_eff ? tx_data[0] : tx_data[DATA_W-1];
         last_d     = tx_last;
         edge_cnt_d = '0;
      end

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               cpol_d  = cfg_cpol;
               cpha_d  = cfg_cpha;
               lsb_d   = cfg_lsb_first;
               div_d   = cfg_div;
               cs_n_d  = ~(NUM_CS'(1) << sel_in);
               state_d = SETUP;
            end
         end
         SETUP: if (tick) state_d = XFER;
         XFER: begin
            if (sample) rx_sr_d = rx_shifted;
            if (shift) begin
               mosi_d  = lsb_q ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
               tx_sr_d = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
            end
            if (any_edge && !last_edge) edge_cnt_d = edge_cnt_q + 1'b1;
            if (last_edge) begin
               rx_data_d  = sample ? rx_shifted : rx_sr_q;
               rx_valid_d = 1'b1;
               state_d    = NEXT;
            end
         end
         NEXT: begin
            if (last_q) state_d = HOLD;
            else if (accept) state_d = SETUP;
         end
         HOLD: begin
            if (tick) begin
               cs_n_d  = '1;
               state_d = DESEL;
            end
         end
         DESEL: if (tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      tx_ready_d = (state_d == IDLE) || ((state_d == NEXT) && !last_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         edge_cnt_q <= '0;
         div_q      <= '0;
         cs_n_q     <= '1;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         lsb_q      <= 1'b0;
         last_q     <= 1'b0;
         mosi_q     <= 1'b0;
         tx_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         edge_cnt_q <= edge_cnt_d;
         div_q      <= div_d;
         cs_n_q     <= cs_n_d;
         cpol_q     <= cpol_d;
         cpha_q     <= cpha_d;
         lsb_q      <= lsb_d;
         last_q     <= last_d;
         mosi_q     <= mosi_d;
         tx_ready_q <= tx_ready_d;
      end
   end

   assign tx_ready = tx_ready_q;
   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;
   assign busy     = (state_q != IDLE);
   assign mosi     = mosi_q;
   assign cs_n     = cs_n_q;

endmodule
